// File: rtl/nibble_serial_addsub.sv
// Nibble-serial 16-bit saturating add/subtract unit.
// Runs one 4-bit carry-lookahead adder once per clock, LSB nibble first.
// The carry between nibbles is held in a register. The final nibble
// produces the overflow flag, and the result is then clamped or left to wrap.

module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       gGroup,
    output logic       pGroup,
    output logic       ovfl
);

    logic [3:0] bEff;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Lookahead carries, group generate/propagate, and signed overflow of this nibble
    always_comb begin
        bEff   = b ^ {4{sub}};
        g      = a & bEff;
        p      = a ^ bEff;
        c[0]   = cin | sub;
        c[1]   = g[0] | (p[0] & c[0]);
        c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        gGroup = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pGroup = &p;
        c[4]   = gGroup | (pGroup & c[0]);
        sum    = p ^ c[3:0];
        ovfl   = c[3] ^ c[4];
    end

endmodule

module nibble_serial_addsub #(
    parameter int NIBBLES  = 4,
    parameter int SATURATE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 sub,
    output logic                 ready,
    output logic                 done,
    output logic [4*NIBBLES-1:0] Result,
    output logic                 Z,
    output logic                 V,
    output logic                 N
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q;
    logic [CW-1:0]  count_q;
    logic           carry_q;
    logic [W-1:0]   opA_q;
    logic [W-1:0]   opB_q;
    logic [W-1:0]   partSum_q;
    logic [W-1:0]   result_q;
    logic           z_q;
    logic           v_q;
    logic           n_q;
    logic           done_q;

    logic [3:0]     claSum;
    logic           claG;
    logic           claP;
    logic           claOvfl;
    logic           carry_d;
    logic [W-1:0]   rawSum_d;
    logic [W-1:0]   final_d;

    // B is pre-inverted at acceptance and the +1 enters through the carry
    // register, so the adder instance itself always adds.
    CLA_4bit u_cla (
        .a      (opA_q[count_q*4 +: 4]),
        .b      (opB_q[count_q*4 +: 4]),
        .cin    (carry_q),
        .sub    (1'b0),
        .sum    (claSum),
        .gGroup (claG),
        .pGroup (claP),
        .ovfl   (claOvfl)
    );

    // Next carry, full raw sum with the top nibble spliced in, and the clamped result
    always_comb begin
        carry_d          = claG | (claP & carry_q);
        rawSum_d         = partSum_q;
        rawSum_d[W-1 -: 4] = claSum;
        final_d          = rawSum_d;
        if ((SATURATE != 0) && claOvfl) begin
            final_d = opA_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    // Control FSM with the operand, partial-sum and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            carry_q   <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            partSum_q <= '0;
            result_q  <= '0;
            z_q       <= 1'b0;
            v_q       <= 1'b0;
            n_q       <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_q   <= A;
                        opB_q   <= sub ? ~B : B;
                        carry_q <= sub;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    partSum_q[count_q*4 +: 4] <= claSum;
                    carry_q                   <= carry_d;
                    count_q                   <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        result_q <= final_d;
                        z_q      <= (final_d == '0);
                        v_q      <= claOvfl;
                        n_q      <= final_d[W-1];
                        done_q   <= 1'b1;
                        count_q  <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign Result = result_q;
    assign Z      = z_q;
    assign V      = v_q;
    assign N      = n_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed testbench for nibble_serial_addsub: a saturating and a wrapping
// instance share the same stimulus, and each scenario checks its own outputs.

module tb_nibble_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        subOp;

    logic        ready, done, zFlag, vFlag, nFlag;
    logic [15:0] result;
    logic        ready2, done2, zFlag2, vFlag2, nFlag2;
    logic [15:0] result2;

    int checks;
    int errors;

    nibble_serial_addsub #(.NIBBLES(4), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(opA), .B(opB), .sub(subOp),
        .ready(ready), .done(done), .Result(result), .Z(zFlag), .V(vFlag), .N(nFlag)
    );

    nibble_serial_addsub #(.NIBBLES(4), .SATURATE(0)) dutWrap (
        .clk(clk), .rst_n(rst_n), .start(start), .A(opA), .B(opB), .sub(subOp),
        .ready(ready2), .done(done2), .Result(result2), .Z(zFlag2), .V(vFlag2), .N(nFlag2)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Starts one operation and counts the edges after acceptance until done (-1 on timeout)
    task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output int lat, output bit readyLeak);
        opA   = a;
        opB   = b;
        subOp = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat       = -1;
        readyLeak = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (ready) readyLeak = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        opA = 16'h0; opB = 16'h0; subOp = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (result !== 16'h0 || zFlag !== 1'b0 || vFlag !== 1'b0 || nFlag !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got R=%h Z=%b V=%b N=%b done=%b want all 0", result, zFlag, vFlag, nFlag, done);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b want 1", ready);
        end
    endtask

    task automatic test_basic_add();
        int lat;
        bit leak;
        runOp(16'h1234, 16'h1111, 1'b0, lat, leak);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL basic_latency got %0d want 4", lat);
        end
        checks++;
        if (leak) begin
            errors++;
            $display("[TB] FAIL basic_ready_low got ready=1 during RUN want 0");
        end
        checks++;
        if (result !== 16'h2345 || zFlag !== 1'b0 || vFlag !== 1'b0 || nFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result got R=%h Z=%b V=%b N=%b want R=2345 Z=0 V=0 N=0", result, zFlag, vFlag, nFlag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_width got done=%b want 0", done);
        end
        checks++;
        if (result !== 16'h2345) begin
            errors++;
            $display("[TB] FAIL basic_hold got %h want 2345", result);
        end
    endtask

    task automatic test_carry_chain();
        int lat;
        bit leak;
        runOp(16'h00FF, 16'h0001, 1'b0, lat, leak);
        checks++;
        if (lat !== 4 || result !== 16'h0100 || vFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL carry_00ff got lat=%0d R=%h V=%b want lat=4 R=0100 V=0", lat, result, vFlag);
        end
        @(posedge clk);
        #1;
        runOp(16'hFFFF, 16'h0001, 1'b0, lat, leak);
        checks++;
        if (lat !== 4 || result !== 16'h0000 || zFlag !== 1'b1 || vFlag !== 1'b0 || nFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL carry_ffff got lat=%0d R=%h Z=%b V=%b N=%b want R=0000 Z=1 V=0 N=0", lat, result, zFlag, vFlag, nFlag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pos_sat();
        int lat;
        bit leak;
        runOp(16'h7FFF, 16'h0001, 1'b0, lat, leak);
        checks++;
        if (lat !== 4 || result !== 16'h7FFF || vFlag !== 1'b1 || nFlag !== 1'b0 || zFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pos_sat got lat=%0d R=%h V=%b N=%b Z=%b want R=7FFF V=1 N=0 Z=0", lat, result, vFlag, nFlag, zFlag);
        end
        checks++;
        if (done2 !== 1'b1 || result2 !== 16'h8000 || vFlag2 !== 1'b1 || nFlag2 !== 1'b1 || zFlag2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pos_wrap got done=%b R=%h V=%b N=%b Z=%b want done=1 R=8000 V=1 N=1 Z=0", done2, result2, vFlag2, nFlag2, zFlag2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_neg_sat();
        int lat;
        bit leak;
        runOp(16'h8000, 16'h0001, 1'b1, lat, leak);
        checks++;
        if (lat !== 4 || result !== 16'h8000 || vFlag !== 1'b1 || nFlag !== 1'b1 || zFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL neg_sat got lat=%0d R=%h V=%b N=%b Z=%b want R=8000 V=1 N=1 Z=0", lat, result, vFlag, nFlag, zFlag);
        end
        checks++;
        if (result2 !== 16'h7FFF || vFlag2 !== 1'b1 || nFlag2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL neg_wrap got R=%h V=%b N=%b want R=7FFF V=1 N=0", result2, vFlag2, nFlag2);
        end
        @(posedge clk);
        #1;
        runOp(16'h0005, 16'h0005, 1'b1, lat, leak);
        checks++;
        if (lat !== 4 || result !== 16'h0000 || zFlag !== 1'b1 || vFlag !== 1'b0 || nFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_zero got lat=%0d R=%h Z=%b V=%b N=%b want R=0000 Z=1 V=0 N=0", lat, result, zFlag, vFlag, nFlag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_handshake();
        int lat;
        int extraDone;
        opA = 16'h1234; opB = 16'h1111; subOp = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        opA = 16'h1111; opB = 16'h1111; subOp = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 4 || result !== 16'h2345) begin
            errors++;
            $display("[TB] FAIL ignore_start got lat=%0d R=%h want lat=4 R=2345", lat, result);
        end
        extraDone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) extraDone++;
        end
        checks++;
        if (extraDone !== 0) begin
            errors++;
            $display("[TB] FAIL ignore_no_second_done got %0d done pulses want 0", extraDone);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        bit leak;
        runOp(16'h0100, 16'h0023, 1'b0, lat, leak);
        checks++;
        if (lat !== 4 || result !== 16'h0123 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first got lat=%0d R=%h ready=%b want lat=4 R=0123 ready=1", lat, result, ready);
        end
        opA = 16'h0010; opB = 16'h0020; subOp = 1'b0;
        start = 1'b1;
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
            if (done) begin
                gap = i;
                break;
            end
        end
        checks++;
        if (gap !== 5 || result !== 16'h0030) begin
            errors++;
            $display("[TB] FAIL b2b_second got gap=%0d R=%h want gap=5 R=0030", gap, result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        int doneSeen;
        bit leak;
        opA = 16'h4000; opB = 16'h0001; subOp = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== 16'h0 || zFlag !== 1'b0 || vFlag !== 1'b0 || nFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear got ready=%b done=%b R=%h Z=%b V=%b N=%b want ready=1 rest 0", ready, done, result, zFlag, vFlag, nFlag);
        end
        doneSeen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done got %0d pulses want 0", doneSeen);
        end
        runOp(16'h0003, 16'h0004, 1'b0, lat, leak);
        checks++;
        if (lat !== 4 || result !== 16'h0007) begin
            errors++;
            $display("[TB] FAIL midreset_fresh got lat=%0d R=%h want lat=4 R=0007", lat, result);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs every scenario in order and prints the summary
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_pos_sat();
        test_neg_sat();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- 16-bit saturating add/subtract unit for the ALU datapath.
- Feeds a single instance of the team's 4-bit carry-lookahead adder (CLA_4bit), one nibble per clock, LSB nibble first.
- Chains the carry between nibbles in a register and produces a saturated result with Z/V/N flags.
- Sits directly upstream of the nibble adder. It trades area for latency on the multi-cycle ALU path.

Parameters:
- NIBBLES, 4: number of nibbles processed. Operand width W = 4*NIBBLES.
- SATURATE, 1: 1 = clamp on signed overflow; 0 = wrap (raw two's-complement sum).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request a new operation; accepted only while ready=1.
- A  input  W  operand A, sampled on the accepting edge.
- B  input  W  operand B, sampled on the accepting edge.
- sub  input  1  0 = A+B, 1 = A-B; sampled on the accepting edge.
- ready  output  1  combinational, 1 when state==IDLE.
- done  output  1  registered one-cycle pulse; result and flags valid.
- Result  output  W  registered saturated (or wrapped) result.
- Z  output  1  registered zero flag: Result==0.
- V  output  1  registered signed-overflow flag.
- N  output  1  registered sign flag: Result[W-1].

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, nibble counter=0, carry reg=0.
  - Latched operands, partial sum, Result, Z, V, N, done all cleared to 0.
  - ready=1 from the first cycle after reset.
- Reset mid-operation aborts the operation: no done pulse, and outputs clear to 0.
- FSM states: IDLE, RUN.
- IDLE:
  - On an edge with start=1, latch A, B (B inverted when sub=1) and sub.
  - Set carry reg = sub, counter = 0, go to RUN.
  - done cleared unless being set this edge.
- RUN, each edge: process nibble i = counter.
  - Drive CLA_4bit with A[4i+3:4i], latched B nibble, Cin = carry reg, CLA sub input tied to 0.
  - Inversion and the +1 are done in this block so carries chain correctly across nibbles.
  - Store Sum into partial sum nibble i.
  - carry reg <= G_group | (P_group & carry reg).
  - counter++.
- RUN, edge with counter == NIBBLES-1:
  - Take raw V from the CLA Ovfl output for the top nibble.
  - Compute final Result:
    - if SATURATE=1 and V=1: 0x7FFF-pattern (0, then ones) when latched A[W-1]=0, else 0x8000-pattern (1, then zeros);
    - otherwise the raw sum.
  - Register Result, Z, V, N; set done=1; go to IDLE.
- Latency: start accepted at edge k. Nibbles are processed at edges k+1..k+NIBBLES. done=1 and outputs valid during the cycle after edge k+NIBBLES.
- done is exactly one cycle wide.
- Result and flags hold until the next done pulse or reset.
- start while ready=0 is ignored. Inputs A, B and sub may change freely after acceptance.
- Back-to-back: start in the same cycle as done (ready=1 then) is accepted. The next done follows NIBBLES+1 cycles after the previous one.
- V reflects true signed overflow even when saturated. Z and N are computed from the final (clamped) Result.
- Carry-out of the MSB nibble is discarded (no C flag).

Test Plan:
- Basic add: A=0x1234, B=0x1111, sub=0, start at edge k.
  - Required: done=1 only in the cycle after edge k+4; Result=0x2345, Z=0, V=0, N=0; ready=0 from edge k to edge k+4.
- Carry chain: A=0x00FF, B=0x0001, sub=0.
  - Required: Result=0x0100, V=0.
  - Second case A=0xFFFF, B=0x0001: Result=0x0000, Z=1, V=0, N=0.
- Positive saturation: A=0x7FFF, B=0x0001, sub=0.
  - Required: Result=0x7FFF, V=1, N=0, Z=0.
  - With SATURATE=0: Result=0x8000, V=1, N=1.
- Negative saturation via subtract: A=0x8000, B=0x0001, sub=1.
  - Required: Result=0x8000, V=1, N=1.
  - Second case A=0x0005, B=0x0005, sub=1: Result=0x0000, Z=1, V=0.
- Handshake:
  - start pulsed during RUN with different operands: ignored, and the first result is unaffected.
  - start asserted in the done cycle: accepted, and the second done arrives 5 cycles later.
- Reset mid-operation: rst_n=0 for one edge at k+2.
  - Required: no done pulse; Result/Z/V/N=0; ready=1 the next cycle.
  - A fresh operation (0x0003+0x0004) then returns 0x0007.
